// File: rtl/io_uart_tx_pkg.sv
// io_uart_tx_pkg: shared definitions for the memory-mapped UART transmitter.
//   - register word addresses (addr[7:2])
//   - STATUS bit positions
//   - transmit FSM state enum
package io_uart_tx_pkg;

  // Word addresses decoded from addr[7:2]
  localparam logic [5:0] UART_DATA = 6'h30;  // byte 0xC0
  localparam logic [5:0] UART_STAT = 6'h31;  // byte 0xC4
  localparam logic [5:0] UART_DIV  = 6'h32;  // byte 0xC8

  // STATUS register bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;  // count occupies [7:4]

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/io_uart_tx_if.sv
// io_uart_tx_if: I/O store/read port between the data-memory stage and the UART.
//   addr   : byte address, only addr[7:2] is decoded by the UART
//   datain : store data
//   we     : write strobe, already qualified to the I/O space
//   rdata  : combinational read data for addr
// Handshake: there is no valid/ready pair. A write is a single-cycle strobe;
// when we=1 at a rising clock edge the store is taken in that edge, always,
// with no back-pressure. Reads are combinational with no wait states.
interface io_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, output datain, output we, input rdata);
  modport slave  (input addr, input datain, input we, output rdata);
endinterface

// File: rtl/io_sync_fifo.sv
// io_sync_fifo: single-clock FIFO with occupancy count.
//   clk, rst   : clock, asynchronous active-high reset
//   i_push     : write i_data (dropped when full unless i_pop is also accepted)
//   i_data     : write data
//   i_pop      : advance read pointer (ignored when empty)
//   o_data     : head entry (valid when !o_empty)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_count    : number of entries held
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter in the I/O space.
//   clock, reset : clock, asynchronous active-high reset
//   bus          : I/O store/read port (addr, datain, we in; rdata out)
//   txd          : serial output, idle high
//   o_dbg_state  : current transmit FSM state
// Registers (addr[7:2]): DATA 0x30 (write pushes byte, reads 0),
// STATUS 0x31 (busy/full/empty/overflow/count, write bit3=1 clears overflow),
// DIV 0x32 (clocks per bit, 0 acts as 1).
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic               clock,
  input  logic               reset,
  io_uart_tx_if.slave        bus,
  output logic               txd,
  output tx_state_t          o_dbg_state
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [5:0]       w_word;
  logic             w_wr_data;
  logic             w_wr_stat;
  logic             w_wr_div;
  logic             w_pop;
  logic [7:0]       w_fifo_data;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [DIV_W-1:0] w_div_eff;
  logic             w_bit_end;
  logic [31:0]      w_status;
  logic [31:0]      w_rdata;
  logic             w_unused;

  tx_state_t        r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_idx;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_reload;
  logic [DIV_W-1:0] r_div;
  logic             r_ovf;
  logic             r_txd;

  assign w_word    = bus.addr[7:2];
  assign w_wr_data = bus.we && (w_word == UART_DATA);
  assign w_wr_stat = bus.we && (w_word == UART_STAT);
  assign w_wr_div  = bus.we && (w_word == UART_DIV);
  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign w_div_eff = (r_div == '0) ? DIV_W'(1) : r_div;
  assign w_bit_end = (r_cnt == '0);
  // Only addr[7:2] and a few datain bits matter; the rest are don't-care.
  assign w_unused  = ^{bus.addr, bus.datain};

  io_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_wr_data),
    .i_data  (bus.datain[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Overflow set wins over a clear in the same cycle so a drop is never lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_div <= DIV_W'(DEFAULT_DIV);
    end else begin
      if (w_wr_data && w_full && !w_pop)          r_ovf <= 1'b1;
      else if (w_wr_stat && bus.datain[STAT_OVF]) r_ovf <= 1'b0;
      if (w_wr_div) r_div <= bus.datain[DIV_W-1:0];
    end
  end

  // Transmit FSM. r_reload is captured at the pop so DIV writes mid-frame
  // only take effect on the next frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_reload <= '0;
      r_txd    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift  <= w_fifo_data;
            r_reload <= w_div_eff;
            r_cnt    <= w_div_eff - DIV_W'(1);
            r_txd    <= 1'b0;
            r_state  <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_idx   <= '0;
            r_txd   <= r_shift[0];
            r_cnt   <= r_reload - DIV_W'(1);
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt <= r_reload - DIV_W'(1);
            if (r_idx == 3'd7) begin
              r_state <= STOP;
              r_txd   <= 1'b1;
            end else begin
              // Next bit is shift[1] before the shift lands.
              r_shift <= r_shift >> 1;
              r_txd   <= r_shift[1];
              r_idx   <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_state <= IDLE;
            r_txd   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  // Count field is 4 bits wide; DEPTH up to 8 fits without truncation.
  always_comb begin
    w_status                             = '0;
    w_status[STAT_BUSY]                  = (r_state != IDLE);
    w_status[STAT_FULL]                  = w_full;
    w_status[STAT_EMPTY]                 = w_empty;
    w_status[STAT_OVF]                   = r_ovf;
    w_status[STAT_CNT_LSB+3:STAT_CNT_LSB] = 4'(w_count);
  end

  always_comb begin
    w_rdata = '0;
    case (w_word)
      UART_STAT: w_rdata = w_status;
      UART_DIV:  w_rdata = 32'(r_div);
      default:   w_rdata = '0;
    endcase
  end

  assign bus.rdata   = w_rdata;
  assign txd         = r_txd;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_io_uart_tx.sv
module tb_io_uart_tx;
  import io_uart_tx_pkg::*;

  localparam int DEPTH       = 4;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 434;

  logic      clock = 1'b0;
  logic      reset = 1'b0;
  logic      txd;
  tx_state_t dbg_state;

  io_uart_tx_if bus();

  io_uart_tx #(.DEPTH(DEPTH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .txd         (txd),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.addr   = a;
    bus.datain = d;
    bus.we     = 1'b1;
    @(posedge clock);
    #1;
    bus.we     = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    bus.we   = 1'b0;
    #1;
    check(name, bus.rdata, exp);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
  endtask

  // Expected per-clock txd for one frame: start, 8 data LSB first, stop.
  task automatic add_frame(input logic [7:0] b, input int div);
    for (int k = 0; k < 10*div; k++) begin
      int bp;
      bp = k / div;
      if (bp == 0)      exp_q.push_back(1'b0);
      else if (bp == 9) exp_q.push_back(1'b1);
      else              exp_q.push_back(b[bp-1]);
    end
  endtask

  task automatic check_wave(input string name);
    int n, bad, first;
    logic [0:0] e, g, fe;
    n = exp_q.size(); bad = 0; first = -1; g = 1'b0; fe = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      if (txd !== e[0]) begin
        if (bad == 0) begin first = i; g = txd; fe = e; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d of %0d txd samples wrong, first at sample %0d got %b expected %b",
               name, bad, n, first, g, fe);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.addr = '0; bus.datain = '0; bus.we = 1'b0;
    vecs[0]  = '{we:1'b0, addr:32'h0000_00C0, data:32'h0,         exp:32'h0};
    vecs[1]  = '{we:1'b0, addr:32'h0000_00C4, data:32'h0,         exp:32'h04};
    vecs[2]  = '{we:1'b0, addr:32'h0000_00C8, data:32'h0,         exp:32'd434};
    vecs[3]  = '{we:1'b0, addr:32'h0000_00CC, data:32'h0,         exp:32'h0};
    vecs[4]  = '{we:1'b0, addr:32'h0000_0080, data:32'h0,         exp:32'h0};
    vecs[5]  = '{we:1'b1, addr:32'h0000_00C8, data:32'd4,         exp:32'h0};
    vecs[6]  = '{we:1'b0, addr:32'h0000_00C8, data:32'h0,         exp:32'd4};
    vecs[7]  = '{we:1'b1, addr:32'h0000_00D0, data:32'hFF,        exp:32'h0};
    vecs[8]  = '{we:1'b0, addr:32'h0000_00C8, data:32'h0,         exp:32'd4};
    vecs[9]  = '{we:1'b0, addr:32'h0000_00C4, data:32'h0,         exp:32'h04};
    vecs[10] = '{we:1'b1, addr:32'h0000_00C8, data:32'h0001_0006, exp:32'h0};
    vecs[11] = '{we:1'b0, addr:32'h0000_00C8, data:32'h0,         exp:32'd6};
    vecs[12] = '{we:1'b0, addr:32'hFFFF_FFCA, data:32'h0,         exp:32'd6};
    vecs[13] = '{we:1'b1, addr:32'h0000_00C8, data:32'd4,         exp:32'h0};
    vecs[14] = '{we:1'b0, addr:32'h0000_00C6, data:32'h0,         exp:32'h04};
    vecs[15] = '{we:1'b1, addr:32'h0000_00C4, data:32'hFFFF_FFF7, exp:32'h0};
    vecs[16] = '{we:1'b0, addr:32'h0000_00C4, data:32'h0,         exp:32'h04};

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #1;
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Register map vectors
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
      else rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // 0xA5 at DIV=4
    exp_q.delete();
    add_idle(2);
    add_frame(8'hA5, 4);
    fork
      begin
        wr(32'hC0, 32'hA5);
        rd_check("a5_status_next", 32'hC4, 32'h10);
      end
      check_wave("a5_wave");
    join
    rd_check("a5_busy_last", 32'hC4, 32'h05);
    @(negedge clock);
    rd_check("a5_busy_clear", 32'hC4, 32'h04);

    // Five bytes back-to-back at DIV=2
    wr(32'hC8, 32'd2);
    exp_q.delete();
    add_idle(2);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) add_idle(1);
      add_frame(8'((i + 1) * 8'h11), 2);
    end
    fork
      begin
        for (int i = 0; i < 5; i++) wr(32'hC0, 32'((i + 1) * 8'h11));
        rd_check("b2b_status_full", 32'hC4, 32'h43);
      end
      check_wave("b2b_wave");
    join
    @(negedge clock);
    rd_check("b2b_done", 32'hC4, 32'h04);

    // Overflow while stalled, then clear
    wr(32'hC8, 32'd20);
    wr(32'hC0, 32'hA0);
    for (int i = 0; i < 5; i++) wr(32'hC0, 32'hB1 + 32'(i));
    rd_check("ovf_set", 32'hC4, 32'h4B);
    wr(32'hC4, 32'h08);
    rd_check("ovf_clear", 32'hC4, 32'h43);
    begin
      int cyc;
      cyc = 0;
      bus.addr = 32'hC4;
      while (bus.rdata !== 32'h04 && cyc < 2000) begin
        @(negedge clock);
        #1;
        cyc++;
      end
      checks++;
      if (bus.rdata !== 32'h04) begin
        errors++;
        $display("FAIL drain: status 0x%08h after %0d cycles, required 0x00000004", bus.rdata, cyc);
      end
    end

    // DIV=0 behaves as 1
    wr(32'hC8, 32'd0);
    rd_check("div0_read", 32'hC8, 32'd0);
    exp_q.delete();
    add_idle(2);
    add_frame(8'hFF, 1);
    fork
      wr(32'hC0, 32'hFF);
      check_wave("div0_wave");
    join
    @(negedge clock);
    rd_check("div0_done", 32'hC4, 32'h04);

    // DIV change mid-frame only affects the next frame
    wr(32'hC8, 32'd4);
    exp_q.delete();
    add_idle(2);
    add_frame(8'h3C, 4);
    add_idle(1);
    add_frame(8'hC3, 8);
    fork
      begin
        wr(32'hC0, 32'h3C);
        wr(32'hC0, 32'hC3);
        repeat (12) @(negedge clock);
        wr(32'hC8, 32'd8);
        rd_check("divchg_read", 32'hC8, 32'd8);
      end
      check_wave("divchg_wave");
    join
    @(negedge clock);
    rd_check("divchg_done", 32'hC4, 32'h04);

    // Reset during bit 3 of a frame with a second byte queued
    wr(32'hC8, 32'd4);
    wr(32'hC0, 32'hF0);
    wr(32'hC0, 32'h55);
    repeat (17) @(negedge clock);
    check("mid_bit3_txd", 32'(txd), 32'd0);
    check("mid_bit3_state", 32'(dbg_state), 32'(DATA));
    #1 reset = 1'b1;
    #1;
    check("rst_txd_now", 32'(txd), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rd_check("rst_status", 32'hC4, 32'h04);
    rd_check("rst_div", 32'hC8, 32'd434);
    @(negedge clock);
    reset = 1'b0;
    begin
      int lows;
      lows = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clock);
        if (txd !== 1'b1) lows++;
      end
      check("post_rst_quiet", 32'(lows), 32'd0);
    end
    rd_check("post_rst_status", 32'hC4, 32'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped UART transmitter in the I/O space (byte addresses 0x80–0xff) of the single-cycle CPU's data-memory port. It consumes the store traffic that the data-memory stage routes to I/O. Bytes written to its data register are queued in a small FIFO and serialized 8N1 on `txd` at a programmable baud divisor. Status and divisor are readable through the I/O read-data mux.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `DIV_W`, 16: divisor register width.
- `DEFAULT_DIV`, 434: reset divisor, in clocks per bit.

Ports:
- `clock`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `addr`, in, 32: byte address; only `addr[7:2]` is decoded.
- `datain`, in, 32: store data.
- `we`, in, 1: I/O write enable, already qualified to the I/O space by the upstream decoder.
- `rdata`, out, 32: combinational read data for `addr`.
- `txd`, out, 1: serial output; idle high.

## Operation
Register map, by word address `addr[7:2]`:
- 0x30 (byte 0xC0), DATA:
  - Write pushes `datain[7:0]`.
  - Read returns 0.
- 0x31 (0xC4), STATUS, read-only except bit 3:
  - bit0 busy: FSM not in IDLE.
  - bit1 full.
  - bit2 empty.
  - bit3 overflow: sticky. A write with `datain[3]`=1 clears it.
  - bits[7:4] FIFO count.
  - All other bits read 0.
- 0x32 (0xC8), DIV: read/write `datain[DIV_W-1:0]`. A value of 0 behaves as 1.
- Any other I/O word address: reads 0; writes are ignored.

FIFO rules:
- Push when full is dropped and sets overflow, unless a pop occurs in the same cycle. In that case the push is accepted and count is unchanged.
- Pointers wrap modulo `DEPTH`.

Transmit FSM:
- IDLE:
  - `txd`=1.
  - If the FIFO is non-empty: pop into the shift register, latch DIV into the bit-period reload, go to START.
- START: `txd`=0 for one bit period, then DATA with bit index 0.
- DATA:
  - `txd` = shift[0] for one bit period.
  - Then shift right and increment the index.
  - After index 7 completes, go to STOP.
- STOP: `txd`=1 for one bit period, then IDLE.
- The bit-period counter loads `div-1` on entry to each bit and advances the state when it reaches 0.
- A DIV write mid-frame affects only the next frame.

## Timing
- Reset values, asserted asynchronously:
  - `txd`=1.
  - FSM in IDLE.
  - FIFO empty, overflow=0.
  - DIV=`DEFAULT_DIV`.
  - `rdata` reflects the reset registers.
- A reset mid-frame aborts the frame; `txd` returns high immediately.
- Write latency: a write in cycle N is visible in STATUS/DIV reads in cycle N+1.
- Start-of-frame latency:
  - Push at edge N into an empty FIFO with FSM idle.
  - Pop at edge N+1.
  - `txd` falls after edge N+1.
  - Busy reads 1 from cycle N+1 onward.
- Frame length is exactly 10×div clocks. Back-to-back frames are separated by one IDLE cycle (the pop cycle).
- Simultaneous push to an empty FIFO and an idle FSM: the push lands first; the pop occurs the following cycle.
- `rdata` is purely combinational from `addr` and current state, with no wait states.

## Structure
- Shared package:
  - Register word-address constants (`UART_DATA`, `UART_STAT`, `UART_DIV`).
  - STATUS bit positions.
  - FSM state enum (IDLE/START/DATA/STOP).
- One sub-module, `io_sync_fifo` (parameters: width 8, `DEPTH`):
  - push/pop/full/empty/count interface.
  - Same-cycle push+pop when full is allowed.
- The top level holds the register decode, DIV register, FSM, bit counter and shift register.

## Test plan
- Reset with DIV=4: `txd`=1, STATUS=0x04, DIV reads 434 → after writing DIV=4, DIV reads 4.
- DIV=4; write DATA=0xA5 → `txd` low for 4 clocks, then 1,0,1,0,0,1,0,1 (LSB first), 4 clocks each, then high for 4 clocks; busy clears at clock 41 after the push.
- DIV=2; write 0x11, 0x22, 0x33, 0x44, 0x55 in consecutive cycles → count peaks at 4 after the first pop, all five bytes are emitted back-to-back, and overflow stays 0 (pop coincided). Then five writes while stalled → overflow=1; writing STATUS 0x08 → overflow=0.
- DIV=0 → each bit lasts 1 clock; a frame of 0xFF shows `txd` low for exactly 1 clock.
- Write DIV=8 during the DATA bits of a DIV=4 frame → the current frame stays at 4 clocks/bit; the next frame uses 8.
- Assert `reset` during bit 3 of a frame → `txd`=1 immediately, FIFO empty, and no further edges on `txd` after release.
